// File: rtl/ysyx_22051145_mem_stage_pkg.sv
// Shared defines for the memory stage: mem_op codes, FSM state codes
// and small decode helpers used by the stage and its load extender.
package ysyx_22051145_mem_stage_pkg;

    // Memory operation codes carried from execute
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LD   = 4'd4;
    localparam logic [3:0] MEM_LBU  = 4'd5;
    localparam logic [3:0] MEM_LHU  = 4'd6;
    localparam logic [3:0] MEM_LWU  = 4'd7;
    localparam logic [3:0] MEM_SB   = 4'd8;
    localparam logic [3:0] MEM_SH   = 4'd9;
    localparam logic [3:0] MEM_SW   = 4'd10;
    localparam logic [3:0] MEM_SD   = 4'd11;

    // Stage FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // Codes above SD are not defined and behave like a plain ALU op
    function automatic logic [3:0] decode_op(input logic [3:0] op);
        return (op > MEM_SD) ? MEM_NONE : op;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LWU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SD);
    endfunction

    // Natural alignment check on the low address bits for the access size
    function automatic logic is_misaligned(input logic [3:0] op, input logic [2:0] a);
        logic mis;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: mis = a[0];
            MEM_LW, MEM_LWU, MEM_SW: mis = (a[1:0] != 2'b00);
            MEM_LD, MEM_SD:          mis = (a != 3'b000);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-enable pattern for a store, placed at its byte offset in the word
    function automatic logic [7:0] store_strb(input logic [3:0] op, input logic [2:0] a);
        logic [7:0] strb;
        case (op)
            MEM_SB:  strb = 8'h01 << a;
            MEM_SH:  strb = 8'h03 << a;
            MEM_SW:  strb = 8'h0F << a;
            MEM_SD:  strb = 8'hFF;
            default: strb = 8'h00;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ysyx_22051145_mem_stage_load_ext.sv
// Load extender: picks the addressed byte lane(s) out of an aligned
// 64-bit read word and sign- or zero-extends them to 64 bits.
module ysyx_22051145_load_ext
    import ysyx_22051145_mem_stage_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [2:0]  addr_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] result_o
);

    logic [63:0] shifted;

    assign shifted = rdata_i >> {addr_i, 3'b000};

    // Extend the lane that now sits at the bottom of the word
    always_comb begin
        result_o = shifted;
        case (op_i)
            MEM_LB:  result_o = {{56{shifted[7]}},  shifted[7:0]};
            MEM_LH:  result_o = {{48{shifted[15]}}, shifted[15:0]};
            MEM_LW:  result_o = {{32{shifted[31]}}, shifted[31:0]};
            MEM_LBU: result_o = {56'd0, shifted[7:0]};
            MEM_LHU: result_o = {48'd0, shifted[15:0]};
            MEM_LWU: result_o = {32'd0, shifted[31:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22051145_mem_stage.sv
// Memory stage: takes one instruction from execute, performs at most one
// data-memory access, and presents the result to writeback. Only XLEN=64
// is meaningful; the byte-lane logic assumes an 8-byte word.
module ysyx_22051145_mem_stage
    import ysyx_22051145_mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [3:0]      ex_mem_op,
    input  logic [4:0]      ex_rd_idx,
    input  logic            ex_rd_en,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [7:0]      dmem_req_wstrb,
    output logic [XLEN-1:0] dmem_req_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd_idx,
    output logic            wb_rd_en,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            wb_misalign
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      op_q, op_d;
    logic [4:0]      rdIdx_q, rdIdx_d;
    logic            rdEn_q, rdEn_d;
    logic [XLEN-1:0] rdData_q, rdData_d;
    logic            misalign_q, misalign_d;

    logic [3:0]      exOp;
    logic [2:0]      exByteOff;
    logic            exIsStore;
    logic            exIsMem;
    logic            exMisalign;
    logic            accept;
    logic [XLEN-1:0] loadResult;

    assign exOp       = decode_op(ex_mem_op);
    assign exByteOff  = ex_alu_res[2:0];
    assign exIsStore  = is_store(exOp);
    assign exIsMem    = is_load(exOp) || exIsStore;
    assign exMisalign = is_misaligned(exOp, exByteOff);

    // New work is taken when idle, or when the current result leaves this cycle
    assign ex_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && wb_ready);
    assign accept   = ex_valid && ex_ready;

    ysyx_22051145_load_ext u_load_ext (
        .op_i     (op_q),
        .addr_i   (addr_q[2:0]),
        .rdata_i  (dmem_rsp_rdata),
        .result_o (loadResult)
    );

    // Next-state logic: FSM progression plus latching of a newly accepted op
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rdIdx_d    = rdIdx_q;
        rdEn_d     = rdEn_q;
        rdData_d   = rdData_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = ST_OUT;
                    if (is_load(op_q)) begin
                        rdData_d = loadResult;
                    end
                end
            end
            ST_OUT: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the OUT->IDLE move so back-to-back ops stream
        if (accept) begin
            pc_d       = ex_pc;
            addr_d     = ex_alu_res;
            op_d       = exOp;
            rdIdx_d    = ex_rd_idx;
            misalign_d = exMisalign;
            rdData_d   = ex_alu_res;
            rdEn_d     = ex_rd_en && (ex_rd_idx != 5'd0) && !exIsStore && !exMisalign;
            wstrb_d    = (exIsStore && !exMisalign) ? store_strb(exOp, exByteOff) : 8'h00;
            wdata_d    = exIsStore ? (ex_rs2 << {exByteOff, 3'b000}) : '0;
            state_d    = (exIsMem && !exMisalign) ? ST_REQ : ST_OUT;
        end
    end

    // State and latched instruction fields; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            op_q       <= MEM_NONE;
            rdIdx_q    <= '0;
            rdEn_q     <= 1'b0;
            rdData_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rdIdx_q    <= rdIdx_d;
            rdEn_q     <= rdEn_d;
            rdData_q   <= rdData_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign dmem_req_wstrb = wstrb_q;
    assign dmem_req_wdata = wdata_q;

    assign wb_valid    = (state_q == ST_OUT);
    assign wb_pc       = pc_q;
    assign wb_rd_idx   = rdIdx_q;
    assign wb_rd_en    = rdEn_q;
    assign wb_rd_data  = rdData_q;
    assign wb_misalign = misalign_q;

endmodule
